// File: rtl/pipe_sequencer_pkg.sv
// rtl/pipe_sequencer_pkg.sv - pipe_seq_pkg: state encoding, hazard priorities, control-word constants
package pipe_seq_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } seq_state_e;

  // Ordered lowest to highest so a larger value always wins.
  typedef enum logic [1:0] {
    PRI_NONE     = 2'd0,
    PRI_LOAD_USE = 2'd1,
    PRI_BRANCH   = 2'd2,
    PRI_MEM_WAIT = 2'd3
  } hazard_pri_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_write;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_STOP     = 7'b000_0000;
  localparam pipe_ctl_t CTL_FLOW     = 7'b110_1011;
  localparam pipe_ctl_t CTL_BRANCH   = 7'b111_1111;
  localparam pipe_ctl_t CTL_LOAD_USE = 7'b000_1111;
  // Front end frozen and fed bubbles while the halt walks down the pipe.
  localparam pipe_ctl_t CTL_DRAIN    = 7'b011_1011;

endpackage

// File: rtl/pipe_sequencer_if.sv
// rtl/pipe_sequencer_if.sv - datapath <-> sequencer hazard inputs and register enables
interface pipe_sequencer_if;

  logic [4:0] IdRs;
  logic [4:0] IdRt;
  logic       ExMemRead;
  logic [4:0] ExWrReg;
  logic       BranchTaken;
  logic       HaltId;
  logic       HaltWb;
  logic       MemReq;
  logic       MemReady;
  logic       PcWrite;
  logic       IfIdWrite;
  logic       IfIdFlush;
  logic       IdExWrite;
  logic       IdExFlush;
  logic       ExMemWrite;
  logic       MemWbWrite;
  logic       Halted;
  logic       DrainErr;

  modport master (
    output IdRs, IdRt, ExMemRead, ExWrReg, BranchTaken, HaltId, HaltWb, MemReq, MemReady,
    input  PcWrite, IfIdWrite, IfIdFlush, IdExWrite, IdExFlush, ExMemWrite, MemWbWrite,
    input  Halted, DrainErr
  );

  modport slave (
    input  IdRs, IdRt, ExMemRead, ExWrReg, BranchTaken, HaltId, HaltWb, MemReq, MemReady,
    output PcWrite, IfIdWrite, IfIdFlush, IdExWrite, IdExFlush, ExMemWrite, MemWbWrite,
    output Halted, DrainErr
  );

endinterface

// File: rtl/pipe_sequencer_hazard_detect.sv
// rtl/pipe_sequencer_hazard_detect.sv - load-use hazard between the load in EX and the instruction in ID
module hazard_detect
  import pipe_seq_pkg::*;
(
  input  logic [4:0] IdRs,
  input  logic [4:0] IdRt,
  input  logic       ExMemRead,
  input  logic [4:0] ExWrReg,
  output logic       LoadUse
);

  // A load into $zero produces nothing to forward, so it never stalls.
  assign LoadUse = ExMemRead && (ExWrReg != REG_ZERO) &&
                   ((ExWrReg == IdRs) || (ExWrReg == IdRt));

endmodule

// File: rtl/pipe_sequencer.sv
// rtl/pipe_sequencer.sv - stall/flush/halt controller for the 5-stage pipeline
// Optional perf counters StallCnt/FlushCnt when PIPE_PERF_EN is defined.
module pipe_sequencer
  import pipe_seq_pkg::*;
#(
  parameter int DRAIN_MAX = 8
`ifdef PIPE_PERF_EN
  ,
  parameter int CNT_W     = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  pipe_sequencer_if.slave    bus
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]   StallCnt,
  output logic [CNT_W-1:0]   FlushCnt
`endif
);

  localparam int DCW = (DRAIN_MAX > 2) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_MAX - 1);

  seq_state_e     state_q, state_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
  logic           from_drain_q, from_drain_d;
  logic           halted_q, halted_d;
  logic           drain_err_q, drain_err_d;
  logic           load_use;
  logic           drain_mode;
  hazard_pri_e    pri;
  pipe_ctl_t      ctl;

  hazard_detect u_hazard (
    .IdRs      (bus.IdRs),
    .IdRt      (bus.IdRt),
    .ExMemRead (bus.ExMemRead),
    .ExWrReg   (bus.ExWrReg),
    .LoadUse   (load_use)
  );

  always_comb begin
    pri = PRI_NONE;
    if (bus.MemReq && !bus.MemReady) pri = PRI_MEM_WAIT;
    else if (bus.BranchTaken)        pri = PRI_BRANCH;
    else if (load_use)               pri = PRI_LOAD_USE;
  end

  // MEM_WAIT resumes with the rules of whichever mode it interrupted.
  assign drain_mode = (state_q == ST_DRAIN) || ((state_q == ST_MEM_WAIT) && from_drain_q);

  always_comb begin
    ctl          = CTL_STOP;
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    from_drain_d = from_drain_q;
    halted_d     = halted_q;
    drain_err_d  = drain_err_q;
    if (state_q != ST_HALTED) begin
      if (pri == PRI_MEM_WAIT) begin
        state_d      = ST_MEM_WAIT;
        from_drain_d = drain_mode;
      end else if (drain_mode) begin
        ctl = CTL_DRAIN;
        if (bus.HaltWb) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d     = ST_HALTED;
          halted_d    = 1'b1;
          drain_err_d = 1'b1;
        end else begin
          state_d     = ST_DRAIN;
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end else begin
        state_d      = ST_RUN;
        from_drain_d = 1'b0;
        case (pri)
          PRI_BRANCH:   ctl = CTL_BRANCH;
          PRI_LOAD_USE: ctl = CTL_LOAD_USE;
          default: begin
            if (bus.HaltId) begin
              ctl         = CTL_DRAIN;
              state_d     = ST_DRAIN;
              drain_cnt_d = '0;
            end else begin
              ctl = CTL_FLOW;
            end
          end
        endcase
      end
    end
  end

`ifdef PIPE_PERF_EN
  logic             stall_evt, flush_evt;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  assign stall_evt = (state_q != ST_HALTED) &&
                     ((pri == PRI_MEM_WAIT) || (!drain_mode && (pri == PRI_LOAD_USE)));
  assign flush_evt = (state_q != ST_HALTED) && !drain_mode && (pri == PRI_BRANCH);
  assign StallCnt  = stall_cnt_q;
  assign FlushCnt  = flush_cnt_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      drain_cnt_q  <= '0;
      from_drain_q <= 1'b0;
      halted_q     <= 1'b0;
      drain_err_q  <= 1'b0;
`ifdef PIPE_PERF_EN
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      from_drain_q <= from_drain_d;
      halted_q     <= halted_d;
      drain_err_q  <= drain_err_d;
`ifdef PIPE_PERF_EN
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
`endif
    end
  end

  assign bus.PcWrite    = ctl.pc_write     & ~reset;
  assign bus.IfIdWrite  = ctl.if_id_write  & ~reset;
  assign bus.IfIdFlush  = ctl.if_id_flush  & ~reset;
  assign bus.IdExWrite  = ctl.id_ex_write  & ~reset;
  assign bus.IdExFlush  = ctl.id_ex_flush  & ~reset;
  assign bus.ExMemWrite = ctl.ex_mem_write & ~reset;
  assign bus.MemWbWrite = ctl.mem_wb_write & ~reset;
  assign bus.Halted     = halted_q;
  assign bus.DrainErr   = drain_err_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// tb/tb_pipe_sequencer.sv - directed self-checking bench for pipe_sequencer
module tb_pipe_sequencer;

  localparam logic [6:0] E_STOP  = 7'b000_0000;
  localparam logic [6:0] E_FLOW  = 7'b110_1011;
  localparam logic [6:0] E_BR    = 7'b111_1111;
  localparam logic [6:0] E_LU    = 7'b000_1111;
  localparam logic [6:0] E_DRAIN = 7'b011_1011;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] outs;
  int         checks = 0;
  int         failures = 0;

  pipe_sequencer_if bus ();

`ifdef PIPE_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  pipe_sequencer #(.DRAIN_MAX(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef PIPE_PERF_EN
    ,
    .StallCnt (stall_cnt),
    .FlushCnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign outs = {bus.PcWrite, bus.IfIdWrite, bus.IfIdFlush, bus.IdExWrite,
                 bus.IdExFlush, bus.ExMemWrite, bus.MemWbWrite};

  task automatic idle();
    bus.IdRs = 5'd0; bus.IdRt = 5'd0; bus.ExMemRead = 1'b0; bus.ExWrReg = 5'd0;
    bus.BranchTaken = 1'b0; bus.HaltId = 1'b0; bus.HaltWb = 1'b0;
    bus.MemReq = 1'b0; bus.MemReady = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    bus.HaltId = 1'b1;
    @(negedge clk);
    checks++; if (outs !== E_STOP) begin failures++; $display("FAIL reset_enables got=%b exp=%b", outs, E_STOP); end
    checks++; if (bus.Halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", bus.Halted); end
    checks++; if (bus.DrainErr !== 1'b0) begin failures++; $display("FAIL reset_drainerr got=%b exp=0", bus.DrainErr); end
    tick();
    reset = 1'b0;
    idle();
    @(negedge clk);
    checks++; if (outs !== E_FLOW) begin failures++; $display("FAIL reset_release got=%b exp=%b", outs, E_FLOW); end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    bus.ExMemRead = 1'b1; bus.ExWrReg = 5'd5; bus.IdRs = 5'd5;
    @(negedge clk);
    checks++; if (outs !== E_LU) begin failures++; $display("FAIL load_use_rs got=%b exp=%b", outs, E_LU); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (outs !== E_FLOW) begin failures++; $display("FAIL load_use_clear got=%b exp=%b", outs, E_FLOW); end
    tick();
    bus.ExMemRead = 1'b1; bus.ExWrReg = 5'd17; bus.IdRs = 5'd3; bus.IdRt = 5'd17;
    @(negedge clk);
    checks++; if (outs !== E_LU) begin failures++; $display("FAIL load_use_rt got=%b exp=%b", outs, E_LU); end
    tick();
    bus.ExMemRead = 1'b0;
    @(negedge clk);
    checks++; if (outs !== E_FLOW) begin failures++; $display("FAIL no_load_match got=%b exp=%b", outs, E_FLOW); end
    tick();
    idle();
    bus.ExMemRead = 1'b1; bus.ExWrReg = 5'd0; bus.IdRs = 5'd0;
    @(negedge clk);
    checks++; if (outs !== E_FLOW) begin failures++; $display("FAIL load_use_zero got=%b exp=%b", outs, E_FLOW); end
    tick();
    idle();
  endtask

  task automatic test_branch();
    idle();
    bus.ExMemRead = 1'b1; bus.ExWrReg = 5'd5; bus.IdRs = 5'd5; bus.BranchTaken = 1'b1;
    @(negedge clk);
    checks++; if (outs !== E_BR) begin failures++; $display("FAIL branch_over_lu got=%b exp=%b", outs, E_BR); end
    tick();
    idle();
    bus.BranchTaken = 1'b1; bus.HaltId = 1'b1;
    @(negedge clk);
    checks++; if (outs !== E_BR) begin failures++; $display("FAIL branch_over_halt got=%b exp=%b", outs, E_BR); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (outs !== E_FLOW) begin failures++; $display("FAIL branch_stays_run got=%b exp=%b", outs, E_FLOW); end
    tick();
  endtask

  task automatic test_mem_wait();
    idle();
    bus.MemReq = 1'b1; bus.MemReady = 1'b0; bus.BranchTaken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (outs !== E_STOP) begin failures++; $display("FAIL mem_wait_%0d got=%b exp=%b", i, outs, E_STOP); end
      tick();
    end
    idle();
    bus.MemReq = 1'b1; bus.MemReady = 1'b1;
    @(negedge clk);
    checks++; if (outs !== E_FLOW) begin failures++; $display("FAIL mem_ready got=%b exp=%b", outs, E_FLOW); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (outs !== E_FLOW) begin failures++; $display("FAIL mem_wait_after got=%b exp=%b", outs, E_FLOW); end
    tick();
  endtask

  task automatic test_halt_drain();
    do_reset();
    bus.HaltId = 1'b1;
    @(negedge clk);
    checks++; if (outs !== E_DRAIN) begin failures++; $display("FAIL halt_decode got=%b exp=%b", outs, E_DRAIN); end
    tick();
    idle();
    for (int i = 1; i <= 3; i++) begin
      bus.HaltWb = (i == 3);
      @(negedge clk);
      checks++; if (outs !== E_DRAIN || bus.Halted !== 1'b0) begin
        failures++; $display("FAIL halt_drain_%0d got=%b/%b exp=%b/0", i, outs, bus.Halted, E_DRAIN);
      end
      tick();
    end
    bus.HaltWb = 1'b0;
    bus.ExMemRead = 1'b1; bus.ExWrReg = 5'd4; bus.IdRt = 5'd4; bus.BranchTaken = 1'b1;
    @(negedge clk);
    checks++; if (bus.Halted !== 1'b1) begin failures++; $display("FAIL halt_halted got=%b exp=1", bus.Halted); end
    checks++; if (bus.DrainErr !== 1'b0) begin failures++; $display("FAIL halt_no_err got=%b exp=0", bus.DrainErr); end
    checks++; if (outs !== E_STOP) begin failures++; $display("FAIL halt_frozen got=%b exp=%b", outs, E_STOP); end
    tick();
    idle();
  endtask

  task automatic test_drain_timeout();
    do_reset();
    bus.HaltId = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (outs !== E_DRAIN || bus.Halted !== 1'b0) begin
        failures++; $display("FAIL timeout_drain_%0d got=%b/%b exp=%b/0", i, outs, bus.Halted, E_DRAIN);
      end
      tick();
    end
    @(negedge clk);
    checks++; if (bus.Halted !== 1'b1 || bus.DrainErr !== 1'b1) begin
      failures++; $display("FAIL timeout_err got=%b%b exp=11", bus.Halted, bus.DrainErr);
    end
    do_reset();
    @(negedge clk);
    checks++; if (bus.Halted !== 1'b0 || bus.DrainErr !== 1'b0 || outs !== E_FLOW) begin
      failures++; $display("FAIL timeout_reset got=%b%b/%b exp=00/%b", bus.Halted, bus.DrainErr, outs, E_FLOW);
    end
    tick();
  endtask

  task automatic test_drain_mem_wait();
    do_reset();
    bus.HaltId = 1'b1;
    tick();
    idle();
    tick();
    bus.MemReq = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (outs !== E_STOP) begin failures++; $display("FAIL drain_wait_%0d got=%b exp=%b", i, outs, E_STOP); end
      tick();
    end
    idle();
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      checks++; if (outs !== E_DRAIN || bus.Halted !== 1'b0) begin
        failures++; $display("FAIL drain_resume_%0d got=%b/%b exp=%b/0", i, outs, bus.Halted, E_DRAIN);
      end
      tick();
    end
    @(negedge clk);
    checks++; if (bus.Halted !== 1'b1 || bus.DrainErr !== 1'b1) begin
      failures++; $display("FAIL drain_wait_frozen got=%b%b exp=11", bus.Halted, bus.DrainErr);
    end
    tick();
  endtask

  task automatic test_halt_wb_wins();
    do_reset();
    bus.HaltId = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 7; i++) tick();
    bus.HaltWb = 1'b1;
    tick();
    idle();
    @(negedge clk);
    checks++; if (bus.Halted !== 1'b1 || bus.DrainErr !== 1'b0) begin
      failures++; $display("FAIL hwb_wins got=%b%b exp=10", bus.Halted, bus.DrainErr);
    end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    bus.HaltId = 1'b1;
    tick();
    idle();
    tick();
    tick();
    do_reset();
    @(negedge clk);
    checks++; if (outs !== E_FLOW) begin failures++; $display("FAIL reset_mid_drain got=%b exp=%b", outs, E_FLOW); end
    tick();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_halt_drain();
    test_drain_timeout();
    test_drain_mem_wait();
    test_halt_wb_wins();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
